// File: rtl/data_memory_sized_pkg.sv
// Shared encodings for the sized data memory: access sizes and FSM states.
package data_memory_sized_pkg;

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/data_memory_sized_lane_align.sv
// Combinational lane steering: store byte enables and replication, load extract and
// extension, and misalignment decode.
module data_memory_sized_lane_align
  import data_memory_sized_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rword[{addr_lo, 3'b000} +: 8];
  assign lane_h = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    byte_en    = 4'b0000;
    wdata_rep  = wdata;
    load_data  = rword;
    misaligned = 1'b0;
    case (size)
      SzByte: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        load_data = is_unsigned ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      SzHalf: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        load_data  = is_unsigned ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
        misaligned = addr_lo[0];
      end
      SzWord: begin
        byte_en    = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_memory_sized.sv
// MIPS data memory with valid/ready request port, sized loads/stores, wait states and
// error flags.
module data_memory_sized
  import data_memory_sized_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              MemWrite,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       WriteData,
  output logic              resp_valid,
  output logic [31:0]       ReadData,
  output logic              misaligned,
  output logic              out_of_range
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              resp_valid_q;
  logic [31:0]       rdata_q;
  logic              mis_q;
  logic              oor_q;

  logic [31:0] mem [DEPTH] = '{default: '0};

  logic [IdxW-1:0] idx;
  logic [31:0]     rword;
  logic [3:0]      byte_en;
  logic [31:0]     wdata_rep;
  logic [31:0]     load_data;
  logic            mis_d;
  logic            oor_d;
  logic            access;

  assign idx    = addr_q[2 +: IdxW];
  assign rword  = mem[idx];
  // Any address bit above the word index means the request falls outside the array.
  assign oor_d  = (addr_q >> (2 + IdxW)) != '0;
  assign access = (state_q == StWait) && (cnt_q == 4'd0);

  assign req_ready    = (state_q == StIdle) && !rst;
  assign resp_valid   = resp_valid_q;
  assign ReadData     = rdata_q;
  assign misaligned   = mis_q;
  assign out_of_range = oor_q;

  data_memory_sized_lane_align u_lane_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .addr_lo     (addr_q[1:0]),
    .wdata       (wdata_q),
    .rword       (rword),
    .byte_en     (byte_en),
    .wdata_rep   (wdata_rep),
    .load_data   (load_data),
    .misaligned  (mis_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'h0;
      mis_q        <= 1'b0;
      oor_q        <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q    <= MemWrite;
            size_q  <= size;
            uns_q   <= is_unsigned;
            addr_q  <= Address;
            wdata_q <= WriteData;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q      <= StResp;
            resp_valid_q <= 1'b1;
            rdata_q      <= (we_q || mis_d || oor_d) ? 32'h0 : load_data;
            mis_q        <= mis_d;
            oor_q        <= oor_d;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && access && we_q && !mis_d && !oor_d) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench: one instance with defaults, one with DEPTH=16 / WAIT_CYCLES=3.
module tb_data_memory_sized;

  logic        clk = 1'b0;
  logic        rst0, rst1, rv0, rv1;
  logic        MemWrite, is_unsigned;
  logic [1:0]  size;
  logic [31:0] Address, WriteData;
  logic        rr0, rsp0, mis0, oor0;
  logic        rr1, rsp1, mis1, oor1;
  logic [31:0] rd0, rd1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_memory_sized u0 (
    .clk          (clk),
    .rst          (rst0),
    .req_valid    (rv0),
    .req_ready    (rr0),
    .MemWrite     (MemWrite),
    .size         (size),
    .is_unsigned  (is_unsigned),
    .Address      (Address),
    .WriteData    (WriteData),
    .resp_valid   (rsp0),
    .ReadData     (rd0),
    .misaligned   (mis0),
    .out_of_range (oor0)
  );

  data_memory_sized #(.DEPTH(16), .ADDR_W(32), .WAIT_CYCLES(3)) u1 (
    .clk          (clk),
    .rst          (rst1),
    .req_valid    (rv1),
    .req_ready    (rr1),
    .MemWrite     (MemWrite),
    .size         (size),
    .is_unsigned  (is_unsigned),
    .Address      (Address),
    .WriteData    (WriteData),
    .resp_valid   (rsp1),
    .ReadData     (rd1),
    .misaligned   (mis1),
    .out_of_range (oor1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request on the selected instance and return the response.
  task automatic req(input int which, input logic we, input logic [1:0] sz,
                     input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rd, output logic mis, output logic oor);
    int cyc;
    int exp_lat;
    exp_lat = (which != 0) ? 5 : 2;
    @(negedge clk);
    MemWrite    = we;
    size        = sz;
    is_unsigned = uns;
    Address     = addr;
    WriteData   = wdata;
    if (which != 0) rv1 = 1'b1;
    else rv0 = 1'b1;
    cyc = 0;
    while (!((which != 0) ? rr1 : rr0) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    rv0 = 1'b0;
    rv1 = 1'b0;
    cyc = 1;
    while (!((which != 0) ? rsp1 : rsp0) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(exp_lat));
    rd  = (which != 0) ? rd1 : rd0;
    mis = (which != 0) ? mis1 : mis0;
    oor = (which != 0) ? oor1 : oor0;
    @(negedge clk);
    chk("pulse_one_cycle", {31'h0, (which != 0) ? rsp1 : rsp0}, 32'h0);
  endtask

  logic [31:0] rd;
  logic        mis, oor;
  logic [31:0] a6 [4];
  logic [31:0] d6 [4];
  int          acc6 [4];
  int          nacc, nresp, cyc, seen;

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rv0 = 1'b0; rv1 = 1'b0;
    MemWrite = 1'b0; size = 2'b10; is_unsigned = 1'b0; Address = 32'h0; WriteData = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_resp_valid", {31'h0, rsp0}, 32'h0);
    chk("reset_rdata", rd0, 32'h0);
    chk("reset_flags", {30'h0, mis0, oor0}, 32'h0);
    chk("ready_low_in_rst", {31'h0, rr0}, 32'h0);
    rst0 = 1'b0; rst1 = 1'b0;
    #1 chk("ready_after_rst", {31'h0, rr0}, 32'h1);

    // 1: word store/load
    req(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, mis, oor);
    req(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, mis, oor);
    chk("lw_0x10", rd, 32'hDEADBEEF);
    chk("lw_0x10_flags", {30'h0, mis, oor}, 32'h0);

    // 2: byte store, signed/unsigned byte loads
    req(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, rd, mis, oor);
    req(0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h00000080, rd, mis, oor);
    req(0, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, rd, mis, oor);
    chk("lb_0x21", rd, 32'hFFFFFF80);
    req(0, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, rd, mis, oor);
    chk("lbu_0x21", rd, 32'h00000080);
    req(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, mis, oor);
    chk("lw_0x20", rd, 32'h00008000);

    // 3: upper half store, misaligned half load
    req(0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0, rd, mis, oor);
    req(0, 1'b1, 2'b01, 1'b0, 32'h32, 32'h00001234, rd, mis, oor);
    req(0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, mis, oor);
    chk("lw_0x30", rd, 32'h12340000);
    req(0, 1'b0, 2'b01, 1'b0, 32'h32, 32'h0, rd, mis, oor);
    chk("lh_0x32", rd, 32'h00001234);
    req(0, 1'b0, 2'b01, 1'b0, 32'h31, 32'h0, rd, mis, oor);
    chk("lh_0x31_mis", {31'h0, mis}, 32'h1);
    chk("lh_0x31_rdata", rd, 32'h0);
    req(0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, mis, oor);
    chk("lw_0x30_again", rd, 32'h12340000);
    chk("lw_0x30_mis_clear", {31'h0, mis}, 32'h0);

    // 4: out of range store, illegal size
    req(0, 1'b1, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, rd, mis, oor);
    req(0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h55, rd, mis, oor);
    chk("sw_0x100_oor", {30'h0, mis, oor}, 32'h1);
    req(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, mis, oor);
    chk("lw_0x0_unchanged", rd, 32'hCAFEF00D);
    req(0, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, rd, mis, oor);
    chk("lw_oor_rdata", rd, 32'h0);
    chk("lw_oor_flag", {30'h0, mis, oor}, 32'h1);
    req(0, 1'b0, 2'b11, 1'b0, 32'h8, 32'h0, rd, mis, oor);
    chk("size11_mis", {30'h0, mis, oor}, 32'h2);
    req(0, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, rd, mis, oor);
    chk("both_flags", {30'h0, mis, oor}, 32'h3);

    // 5: reset mid-operation on the wait-state instance
    req(1, 1'b1, 2'b10, 1'b0, 32'h4, 32'h11111111, rd, mis, oor);
    @(negedge clk);
    MemWrite = 1'b1; size = 2'b10; Address = 32'h4; WriteData = 32'hAAAAAAAA; rv1 = 1'b1;
    @(negedge clk);
    rv1 = 1'b0; rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    #1 chk("ready_after_wait_rst", {31'h0, rr1}, 32'h1);
    seen = 0;
    repeat (8) begin @(negedge clk); if (rsp1) seen++; end
    chk("no_resp_wait_rst", 32'(seen), 32'h0);
    @(negedge clk);
    rv1 = 1'b1;
    @(negedge clk);
    rv1 = 1'b0;
    repeat (3) @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    #1 chk("ready_after_access_rst", {31'h0, rr1}, 32'h1);
    seen = 0;
    repeat (8) begin @(negedge clk); if (rsp1) seen++; end
    chk("no_resp_access_rst", 32'(seen), 32'h0);
    req(1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, rd, mis, oor);
    chk("lw_0x4_old", rd, 32'h11111111);

    // 6: back-to-back loads with req_valid held high
    a6[0] = 32'h08; a6[1] = 32'h0C; a6[2] = 32'h10; a6[3] = 32'h14;
    d6[0] = 32'h0A0A0A01; d6[1] = 32'h0B0B0B02; d6[2] = 32'h0C0C0C03; d6[3] = 32'h0D0D0D04;
    for (int i = 0; i < 4; i++) req(1, 1'b1, 2'b10, 1'b0, a6[i], d6[i], rd, mis, oor);
    @(negedge clk);
    MemWrite = 1'b0; size = 2'b10; is_unsigned = 1'b0; Address = a6[0]; rv1 = 1'b1;
    nacc = 0; nresp = 0; cyc = 0;
    while (nresp < 4 && cyc < 100) begin
      if (nacc < 4) Address = a6[nacc];
      else rv1 = 1'b0;
      if (rv1 && rr1) begin
        acc6[nacc] = cyc;
        nacc++;
      end
      @(negedge clk);
      cyc++;
      if (rsp1) begin
        if (nresp < 4) chk("b2b_data", rd1, d6[nresp]);
        nresp++;
      end
    end
    rv1 = 1'b0;
    chk("b2b_accepts", 32'(nacc), 32'h4);
    chk("b2b_resps", 32'(nresp), 32'h4);
    for (int i = 1; i < 4; i++) chk("b2b_spacing", 32'(acc6[i] - acc6[i-1]), 32'h6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
